// File: rtl/hazard_ctrl_if.sv
// Hazard inputs from the pipeline and per-stage enable/flush controls back to it.
// master = hazard_ctrl side, slave = pipeline datapath side.
interface hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       ex_mispredict;
    logic       dmem_busy;

    logic       pc_en;
    logic       redirect_sel;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       back_en;

    modport master (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_mem_read, ex_rd, ex_mispredict, dmem_busy,
        output pc_en, redirect_sel, if_id_en, if_id_flush, id_ex_flush, back_en
    );

    modport slave (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_mem_read, ex_rd, ex_mispredict, dmem_busy,
        input  pc_en, redirect_sel, if_id_en, if_id_flush, id_ex_flush, back_en
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush sequencer with saturating perf counters; controls are
// zero-latency combinational; dmem_busy freezes everything, mispredict waits out a freeze.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    hazard_ctrl_if.master    hz,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_mispredict_cnt
);
    typedef enum logic {RUN, REDIRECT} state_t;

    localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state_q, state_d;
    logic [3:0]       flush_left_q, flush_left_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;
    logic             lu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            flush_left_q <= '0;
            stall_cnt_q  <= '0;
            mp_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
            stall_cnt_q  <= stall_cnt_d;
            mp_cnt_q     <= mp_cnt_d;
        end
    end

    // ID holds a bubble during REDIRECT, so no real dependency can exist there.
    always_comb begin
        lu = hz.ex_mem_read && (hz.ex_rd != 5'd0) && (state_q == RUN) &&
             ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
              (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));
    end

    always_comb begin
        hz.pc_en        = 1'b0;
        hz.redirect_sel = 1'b0;
        hz.if_id_en     = 1'b0;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_flush  = 1'b0;
        hz.back_en      = 1'b0;
        state_d         = state_q;
        flush_left_d    = flush_left_q;
        stall_cnt_d     = stall_cnt_q;
        mp_cnt_d        = mp_cnt_q;

        if (rst) begin
            state_d      = RUN;
            flush_left_d = '0;
        end else if (hz.dmem_busy) begin
            // full freeze: state and flush_left hold, pending mispredict waits
        end else if (hz.ex_mispredict) begin
            hz.redirect_sel = 1'b1;
            hz.pc_en        = 1'b1;
            hz.if_id_flush  = 1'b1;
            hz.id_ex_flush  = 1'b1;
            hz.back_en      = 1'b1;
            if (mp_cnt_q != CNT_MAX) begin
                mp_cnt_d = mp_cnt_q + 1'b1;
            end
            if (FLUSH_CYCLES > 1) begin
                state_d      = REDIRECT;
                flush_left_d = FLUSH_INIT;
            end else begin
                state_d      = RUN;
                flush_left_d = '0;
            end
        end else if (lu) begin
            hz.id_ex_flush = 1'b1;
            hz.back_en     = 1'b1;
        end else if (state_q == REDIRECT) begin
            hz.pc_en       = 1'b1;
            hz.if_id_flush = 1'b1;
            hz.back_en     = 1'b1;
            flush_left_d   = flush_left_q - 1'b1;
            if (flush_left_q == 4'd1) begin
                state_d = RUN;
            end
        end else begin
            hz.pc_en    = 1'b1;
            hz.if_id_en = 1'b1;
            hz.back_en  = 1'b1;
        end

        if (!rst && !hz.pc_en && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign perf_stall_cnt      = stall_cnt_q;
    assign perf_mispredict_cnt = mp_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_read = 0, ex_mispredict = 0, dmem_busy = 0;

    hazard_ctrl_if hz_a ();
    hazard_ctrl_if hz_b ();

    assign hz_a.id_rs1 = id_rs1;           assign hz_b.id_rs1 = id_rs1;
    assign hz_a.id_rs2 = id_rs2;           assign hz_b.id_rs2 = id_rs2;
    assign hz_a.id_uses_rs1 = id_uses_rs1; assign hz_b.id_uses_rs1 = id_uses_rs1;
    assign hz_a.id_uses_rs2 = id_uses_rs2; assign hz_b.id_uses_rs2 = id_uses_rs2;
    assign hz_a.ex_mem_read = ex_mem_read; assign hz_b.ex_mem_read = ex_mem_read;
    assign hz_a.ex_rd = ex_rd;             assign hz_b.ex_rd = ex_rd;
    assign hz_a.ex_mispredict = ex_mispredict; assign hz_b.ex_mispredict = ex_mispredict;
    assign hz_a.dmem_busy = dmem_busy;     assign hz_b.dmem_busy = dmem_busy;

    logic [3:0]  stall_a, mp_a;
    logic [15:0] stall_b, mp_b;

    hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .hz(hz_a.master),
        .perf_stall_cnt(stall_a), .perf_mispredict_cnt(mp_a)
    );
    hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .hz(hz_b.master),
        .perf_stall_cnt(stall_b), .perf_mispredict_cnt(mp_b)
    );

    // control word order: {pc_en, if_id_en, if_id_flush, id_ex_flush, back_en, redirect_sel}
    localparam logic [5:0] OFF   = 6'b000000;
    localparam logic [5:0] NORM  = 6'b110010;
    localparam logic [5:0] STALL = 6'b000110;
    localparam logic [5:0] MP    = 6'b101111;
    localparam logic [5:0] RDF   = 6'b101010;

    int checks = 0;
    int errors = 0;

    function automatic logic [5:0] ctl_a();
        return {hz_a.pc_en, hz_a.if_id_en, hz_a.if_id_flush, hz_a.id_ex_flush, hz_a.back_en, hz_a.redirect_sel};
    endfunction
    function automatic logic [5:0] ctl_b();
        return {hz_b.pc_en, hz_b.if_id_en, hz_b.if_id_flush, hz_b.id_ex_flush, hz_b.back_en, hz_b.redirect_sel};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2,
                         input logic mr, input logic [4:0] rd, input logic mp, input logic busy);
        id_rs1 = r1; id_rs2 = r2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_mem_read = mr; ex_rd = rd; ex_mispredict = mp; dmem_busy = busy;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Pulse reset and leave the design in RUN at a negedge with idle inputs.
    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Advance to the next negedge with the given inputs, then settle.
    task automatic step_lu();
        @(negedge clk);
        drive(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
        #1;
    endtask
    task automatic step_idle();
        @(negedge clk);
        idle();
        #1;
    endtask
    task automatic step_mp(input logic busy);
        @(negedge clk);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, busy);
        #1;
    endtask
    task automatic step_busy();
        @(negedge clk);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        #1;
    endtask

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, mr, mp, busy;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{rs1: 0, rs2: 0, rd: 0, u1: 0, u2: 0, mr: 0, mp: 0, busy: 0, exp: NORM};
        vecs[1]  = '{rs1: 0, rs2: 5, rd: 5, u1: 0, u2: 1, mr: 1, mp: 0, busy: 0, exp: STALL};
        vecs[2]  = '{rs1: 0, rs2: 0, rd: 0, u1: 0, u2: 1, mr: 1, mp: 0, busy: 0, exp: NORM};
        vecs[3]  = '{rs1: 7, rs2: 0, rd: 7, u1: 1, u2: 0, mr: 1, mp: 0, busy: 0, exp: STALL};
        vecs[4]  = '{rs1: 7, rs2: 7, rd: 7, u1: 0, u2: 0, mr: 1, mp: 0, busy: 0, exp: NORM};
        vecs[5]  = '{rs1: 7, rs2: 0, rd: 7, u1: 1, u2: 0, mr: 0, mp: 0, busy: 0, exp: NORM};
        vecs[6]  = '{rs1: 2, rs2: 3, rd: 4, u1: 1, u2: 1, mr: 1, mp: 0, busy: 0, exp: NORM};
        vecs[7]  = '{rs1: 0, rs2: 0, rd: 0, u1: 0, u2: 0, mr: 0, mp: 1, busy: 0, exp: MP};
        vecs[8]  = '{rs1: 0, rs2: 5, rd: 5, u1: 0, u2: 1, mr: 1, mp: 1, busy: 0, exp: MP};
        vecs[9]  = '{rs1: 0, rs2: 0, rd: 0, u1: 0, u2: 0, mr: 0, mp: 0, busy: 1, exp: OFF};
        vecs[10] = '{rs1: 0, rs2: 0, rd: 0, u1: 0, u2: 0, mr: 0, mp: 1, busy: 1, exp: OFF};
        vecs[11] = '{rs1: 9, rs2: 0, rd: 9, u1: 1, u2: 0, mr: 1, mp: 0, busy: 1, exp: OFF};

        // Table: each vector applied from a freshly reset RUN state.
        for (int i = 0; i < 12; i++) begin
            do_reset();
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
                  vecs[i].mr, vecs[i].rd, vecs[i].mp, vecs[i].busy);
            #1;
            check($sformatf("vec%0d_ctl", i), 32'(ctl_a()), 32'(vecs[i].exp));
        end

        // Reset asserted mid-cycle with busy inputs; enables drop immediately.
        do_reset();
        step_lu();
        step_lu();
        #2;
        drive(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_ctl", 32'(ctl_a()), 32'(OFF));
        check("rst_stall_cnt", 32'(stall_a), 32'd0);
        check("rst_mp_cnt", 32'(mp_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        check("post_rst_ctl", 32'(ctl_a()), 32'(NORM));

        // Single load-use bubble, then normal with one stall counted.
        do_reset();
        step_lu();
        check("lu_ctl", 32'(ctl_a()), 32'(STALL));
        step_idle();
        check("lu_after_ctl", 32'(ctl_a()), 32'(NORM));
        check("lu_stall_cnt", 32'(stall_a), 32'd1);

        // Mispredict: 3 flush cycles on A, 1 on B; load-use suppressed in REDIRECT.
        do_reset();
        step_mp(1'b0);
        check("mp_ctl", 32'(ctl_a()), 32'(MP));
        check("mp_ctl_b", 32'(ctl_b()), 32'(MP));
        step_idle();
        check("rdf1_ctl", 32'(ctl_a()), 32'(RDF));
        check("b_after_mp_ctl", 32'(ctl_b()), 32'(NORM));
        check("mp_cnt", 32'(mp_a), 32'd1);
        check("mp_cnt_b", 32'(mp_b), 32'd1);
        step_lu();
        check("rdf2_lu_ctl", 32'(ctl_a()), 32'(RDF));
        step_idle();
        check("mp_done_ctl", 32'(ctl_a()), 32'(NORM));
        check("mp_stall_cnt", 32'(stall_a), 32'd0);

        // Mispredict again inside REDIRECT restarts the flush count.
        do_reset();
        step_mp(1'b0);
        step_idle();
        step_mp(1'b0);
        check("mp2_ctl", 32'(ctl_a()), 32'(MP));
        step_idle();
        check("mp2_rdf1", 32'(ctl_a()), 32'(RDF));
        step_idle();
        check("mp2_rdf2", 32'(ctl_a()), 32'(RDF));
        step_idle();
        check("mp2_done", 32'(ctl_a()), 32'(NORM));
        check("mp2_cnt", 32'(mp_a), 32'd2);

        // Freeze inside REDIRECT stretches the sequence without dropping flushes.
        do_reset();
        step_mp(1'b0);
        for (int i = 0; i < 4; i++) begin
            step_busy();
            check($sformatf("frz%0d_ctl", i), 32'(ctl_a()), 32'(OFF));
        end
        step_idle();
        check("frz_rdf1", 32'(ctl_a()), 32'(RDF));
        step_idle();
        check("frz_rdf2", 32'(ctl_a()), 32'(RDF));
        step_idle();
        check("frz_done", 32'(ctl_a()), 32'(NORM));
        check("frz_stall_cnt", 32'(stall_a), 32'd4);

        // Mispredict held through a freeze is taken when dmem_busy drops.
        do_reset();
        step_mp(1'b1);
        check("mpbusy0_ctl", 32'(ctl_a()), 32'(OFF));
        step_mp(1'b1);
        check("mpbusy1_ctl", 32'(ctl_a()), 32'(OFF));
        check("mpbusy_mp_cnt", 32'(mp_a), 32'd0);
        step_mp(1'b0);
        check("mpbusy_accept", 32'(ctl_a()), 32'(MP));
        step_idle();
        check("mpbusy_rdf", 32'(ctl_a()), 32'(RDF));
        check("mpbusy_mp_cnt2", 32'(mp_a), 32'd1);
        check("mpbusy_stall_cnt", 32'(stall_a), 32'd2);

        // Mispredict together with load-use: no stall counted.
        do_reset();
        @(negedge clk);
        drive(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        #1;
        check("mplu_ctl", 32'(ctl_a()), 32'(MP));
        step_idle();
        check("mplu_stall_cnt", 32'(stall_a), 32'd0);
        check("mplu_mp_cnt", 32'(mp_a), 32'd1);

        // Reset mid-REDIRECT returns to RUN.
        do_reset();
        step_mp(1'b0);
        step_idle();
        #2;
        rst = 1'b1;
        #1;
        check("rst_rdf_ctl", 32'(ctl_a()), 32'(OFF));
        check("rst_rdf_mp_cnt", 32'(mp_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rdf_after", 32'(ctl_a()), 32'(NORM));

        // Saturation: 20 stall cycles, A (4-bit) stops at 15, B keeps counting.
        do_reset();
        for (int i = 0; i < 20; i++) step_lu();
        step_idle();
        check("sat_stall_a", 32'(stall_a), 32'd15);
        check("sat_stall_b", 32'(stall_b), 32'd20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
